// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: default widths, source encoding
// and the round-robin source pick used by the scheduler.
package cdb_arbiter_pkg;

    localparam int unsigned DATA_WID   = 32;
    localparam int unsigned ROB_ID_WID = 4;

    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_LSB = 1'b1;

    // With both sources pending the one that did not win last time goes next.
    function automatic logic pick_src(input logic alu_ne, input logic lsb_ne, input logic last);
        if (alu_ne && lsb_ne) begin
            return ~last;
        end else if (alu_ne) begin
            return CDB_SRC_ALU;
        end else begin
            return CDB_SRC_LSB;
        end
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small synchronous FIFO holding one producer's pending CDB results.
// Flush empties it in one cycle; push is ignored while full, pop while empty.
module cdb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_d;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & (r_count != '0);

    always_comb begin
        w_count_d = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CNT_W'(1);
            2'b01:   w_count_d = r_count - CNT_W'(1);
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_d;
        end
    end

    // Storage needs no reset: entries are only read when count says they are live.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus scheduler: one FIFO per producer (ALU, LSB), round-robin grant of one
// head per cycle onto a registered broadcast bus snooped by every CDB consumer.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_WID,
    parameter int unsigned ROB_ID_W   = ROB_ID_WID,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rdy,
    input  logic                i_rollback,
    input  logic                i_alu_valid,
    input  logic [ROB_ID_W-1:0] i_alu_rob_id,
    input  logic [DATA_W-1:0]   i_alu_data,
    input  logic                i_alu_is_jump,
    input  logic [DATA_W-1:0]   i_alu_jump_pc,
    output logic                o_alu_ready,
    input  logic                i_lsb_valid,
    input  logic [ROB_ID_W-1:0] i_lsb_rob_id,
    input  logic [DATA_W-1:0]   i_lsb_data,
    output logic                o_lsb_ready,
    output logic                o_cdb_valid,
    output logic                o_cdb_src,
    output logic [ROB_ID_W-1:0] o_cdb_rob_id,
    output logic [DATA_W-1:0]   o_cdb_data,
    output logic                o_cdb_is_jump,
    output logic [DATA_W-1:0]   o_cdb_jump_pc
);

    // Payload layout, MSB first: {is_jump, jump_pc, data, rob_id}.
    localparam int unsigned PAY_W = 1 + 2 * DATA_W + ROB_ID_W;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             r_last_grant;
    logic             w_active;
    logic             w_flush;
    logic [PAY_W-1:0] w_alu_pay;
    logic [PAY_W-1:0] w_lsb_pay;
    logic [PAY_W-1:0] w_alu_head;
    logic [PAY_W-1:0] w_lsb_head;
    logic [PAY_W-1:0] w_sel;
    logic [CNT_W-1:0] w_alu_count;
    logic [CNT_W-1:0] w_lsb_count;
    logic             w_alu_full;
    logic             w_lsb_full;
    logic             w_alu_ne;
    logic             w_lsb_ne;
    logic             w_alu_push;
    logic             w_lsb_push;
    logic             w_alu_pop;
    logic             w_lsb_pop;
    logic             w_grant;
    logic             w_grant_src;

    assign w_active = i_rdy & ~i_rollback;
    assign w_flush  = i_rdy & i_rollback;

    assign o_alu_ready = ~w_alu_full;
    assign o_lsb_ready = ~w_lsb_full;

    assign w_alu_pay = {i_alu_is_jump, i_alu_jump_pc, i_alu_data, i_alu_rob_id};
    assign w_lsb_pay = {1'b0, {DATA_W{1'b0}}, i_lsb_data, i_lsb_rob_id};

    assign w_alu_push = w_active & i_alu_valid & ~w_alu_full;
    assign w_lsb_push = w_active & i_lsb_valid & ~w_lsb_full;

    assign w_alu_ne    = (w_alu_count != '0);
    assign w_lsb_ne    = (w_lsb_count != '0);
    assign w_grant     = w_active & (w_alu_ne | w_lsb_ne);
    assign w_grant_src = pick_src(w_alu_ne, w_lsb_ne, r_last_grant);
    assign w_alu_pop   = w_grant & (w_grant_src == CDB_SRC_ALU);
    assign w_lsb_pop   = w_grant & (w_grant_src == CDB_SRC_LSB);
    assign w_sel       = (w_grant_src == CDB_SRC_LSB) ? w_lsb_head : w_alu_head;

    cdb_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_flush),
        .i_push  (w_alu_push),
        .i_data  (w_alu_pay),
        .i_pop   (w_alu_pop),
        .o_head  (w_alu_head),
        .o_count (w_alu_count),
        .o_full  (w_alu_full)
    );

    cdb_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_lsb_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_flush),
        .i_push  (w_lsb_push),
        .i_data  (w_lsb_pay),
        .i_pop   (w_lsb_pop),
        .o_head  (w_lsb_head),
        .o_count (w_lsb_count),
        .o_full  (w_lsb_full)
    );

    // Starting with LSB as last winner lets the ALU take the first collision.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant  <= CDB_SRC_LSB;
            o_cdb_valid   <= 1'b0;
            o_cdb_src     <= 1'b0;
            o_cdb_rob_id  <= '0;
            o_cdb_data    <= '0;
            o_cdb_is_jump <= 1'b0;
            o_cdb_jump_pc <= '0;
        end else if (i_rdy) begin
            if (w_grant) begin
                r_last_grant  <= w_grant_src;
                o_cdb_valid   <= 1'b1;
                o_cdb_src     <= w_grant_src;
                o_cdb_rob_id  <= w_sel[ROB_ID_W-1:0];
                o_cdb_data    <= w_sel[ROB_ID_W +: DATA_W];
                o_cdb_jump_pc <= w_sel[ROB_ID_W + DATA_W +: DATA_W];
                o_cdb_is_jump <= w_sel[PAY_W-1];
            end else begin
                o_cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector tables with hand-computed bus contents per edge,
// plus an asynchronous mid-operation reset sequence.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        rollback;
    logic        alu_valid;
    logic [3:0]  alu_rob_id;
    logic [31:0] alu_data;
    logic        alu_is_jump;
    logic [31:0] alu_jump_pc;
    logic        alu_ready;
    logic        lsb_valid;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_data;
    logic        lsb_ready;
    logic        cdb_valid;
    logic        cdb_src;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_data;
    logic        cdb_is_jump;
    logic [31:0] cdb_jump_pc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rdy;
        logic        rb;
        logic        av;
        logic [3:0]  aid;
        logic [31:0] ad;
        logic        aj;
        logic [31:0] apc;
        logic        lv;
        logic [3:0]  lid;
        logic [31:0] ld;
        logic        ev;
        logic        es;
        logic [3:0]  eid;
        logic [31:0] ed;
        logic        ej;
        logic [31:0] epc;
        logic        ear;
        logic        elr;
    } vec_t;

    cdb_arbiter #(
        .DATA_W     (32),
        .ROB_ID_W   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rdy         (rdy),
        .i_rollback    (rollback),
        .i_alu_valid   (alu_valid),
        .i_alu_rob_id  (alu_rob_id),
        .i_alu_data    (alu_data),
        .i_alu_is_jump (alu_is_jump),
        .i_alu_jump_pc (alu_jump_pc),
        .o_alu_ready   (alu_ready),
        .i_lsb_valid   (lsb_valid),
        .i_lsb_rob_id  (lsb_rob_id),
        .i_lsb_data    (lsb_data),
        .o_lsb_ready   (lsb_ready),
        .o_cdb_valid   (cdb_valid),
        .o_cdb_src     (cdb_src),
        .o_cdb_rob_id  (cdb_rob_id),
        .o_cdb_data    (cdb_data),
        .o_cdb_is_jump (cdb_is_jump),
        .o_cdb_jump_pc (cdb_jump_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Columns: rdy rb | alu valid id data jump pc | lsb valid id data | expected bus | readies
    function automatic vec_t mk(int rdy_i, int rb, int av, int aid, int ad, int aj, int apc,
                                int lv, int lid, int ld, int ev, int es, int eid, int ed,
                                int ej, int epc, int ear, int elr);
        vec_t v;
        v.rdy = 1'(rdy_i); v.rb = 1'(rb);
        v.av = 1'(av); v.aid = 4'(aid); v.ad = 32'(ad); v.aj = 1'(aj); v.apc = 32'(apc);
        v.lv = 1'(lv); v.lid = 4'(lid); v.ld = 32'(ld);
        v.ev = 1'(ev); v.es = 1'(es); v.eid = 4'(eid); v.ed = 32'(ed);
        v.ej = 1'(ej); v.epc = 32'(epc); v.ear = 1'(ear); v.elr = 1'(elr);
        return v;
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%h expected=%h", nm, fld, got, exp);
        end
    endtask

    task automatic check_outs(input vec_t v, input string nm);
        cmp(nm, "cdb_valid",   32'(cdb_valid),   32'(v.ev));
        cmp(nm, "cdb_src",     32'(cdb_src),     32'(v.es));
        cmp(nm, "cdb_rob_id",  32'(cdb_rob_id),  32'(v.eid));
        cmp(nm, "cdb_data",    cdb_data,         v.ed);
        cmp(nm, "cdb_is_jump", 32'(cdb_is_jump), 32'(v.ej));
        cmp(nm, "cdb_jump_pc", cdb_jump_pc,      v.epc);
        cmp(nm, "alu_ready",   32'(alu_ready),   32'(v.ear));
        cmp(nm, "lsb_ready",   32'(lsb_ready),   32'(v.elr));
    endtask

    task automatic set_idle();
        rdy = 1'b1; rollback = 1'b0;
        alu_valid = 1'b0; alu_rob_id = '0; alu_data = '0; alu_is_jump = 1'b0; alu_jump_pc = '0;
        lsb_valid = 1'b0; lsb_rob_id = '0; lsb_data = '0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        rdy = v.rdy; rollback = v.rb;
        alu_valid = v.av; alu_rob_id = v.aid; alu_data = v.ad;
        alu_is_jump = v.aj; alu_jump_pc = v.apc;
        lsb_valid = v.lv; lsb_rob_id = v.lid; lsb_data = v.ld;
        // Offering a result to a full FIFO would lose it.
        if (v.av) cmp(nm, "alu_protocol_ready", 32'(alu_ready), 32'd1);
        if (v.lv) cmp(nm, "lsb_protocol_ready", 32'(lsb_ready), 32'd1);
        @(posedge clk);
        #1;
        check_outs(v, nm);
    endtask

    task automatic run_seq(input vec_t q[$], input string nm);
        foreach (q[i]) run_vec(q[i], $sformatf("%s[%0d]", nm, i));
        set_idle();
    endtask

    vec_t tbl[$];
    vec_t rbq[$];
    vec_t rdq[$];
    vec_t rsq[$];
    vec_t zero_v;

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_v = mk(0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1,1);

        // Collision after reset: ALU first, then LSB.
        tbl.push_back(mk(1,0, 1,1,'hA1,0,0, 1,2,'hB2, 0,0,0,0,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,0,1,'hA1,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,1,2,'hB2,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 0,1,2,'hB2,0,0, 1,1));
        // Single ALU result, one-cycle latency, valid for one edge only.
        tbl.push_back(mk(1,0, 1,3,'h1234,0,0, 0,0,0, 0,1,2,'hB2,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,0,3,'h1234,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 0,0,3,'h1234,0,0, 1,1));
        // Jump payload then an LSB result with zeroed jump fields.
        tbl.push_back(mk(1,0, 1,5,'h55,1,'h100, 0,0,0, 0,0,3,'h1234,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 1,6,'h66, 1,0,5,'h55,1,'h100, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,1,6,'h66,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 0,1,6,'h66,0,0, 1,1));
        // Two back-to-back collisions alternate strictly.
        tbl.push_back(mk(1,0, 1,7,'h77,0,0, 1,8,'h88, 0,1,6,'h66,0,0, 1,1));
        tbl.push_back(mk(1,0, 1,9,'h99,0,0, 1,10,'hAA, 1,0,7,'h77,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,1,8,'h88,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,0,9,'h99,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,1,10,'hAA,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 0,1,10,'hAA,0,0, 1,1));
        // Fill: both push every cycle; LSB full after e6, ALU full after e7, drain in order.
        tbl.push_back(mk(1,0, 1,0,'h100,0,0, 1,8,'h200, 0,1,10,'hAA,0,0, 1,1));
        tbl.push_back(mk(1,0, 1,1,'h101,0,0, 1,9,'h201, 1,0,0,'h100,0,0, 1,1));
        tbl.push_back(mk(1,0, 1,2,'h102,0,0, 1,10,'h202, 1,1,8,'h200,0,0, 1,1));
        tbl.push_back(mk(1,0, 1,3,'h103,0,0, 1,11,'h203, 1,0,1,'h101,0,0, 1,1));
        tbl.push_back(mk(1,0, 1,4,'h104,0,0, 1,12,'h204, 1,1,9,'h201,0,0, 1,1));
        tbl.push_back(mk(1,0, 1,5,'h105,0,0, 1,13,'h205, 1,0,2,'h102,0,0, 1,0));
        tbl.push_back(mk(1,0, 1,6,'h106,0,0, 0,0,0, 1,1,10,'h202,0,0, 0,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,0,3,'h103,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,1,11,'h203,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,0,4,'h104,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,1,12,'h204,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,0,5,'h105,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,1,13,'h205,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,0,6,'h106,0,0, 1,1));
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 0,0,6,'h106,0,0, 1,1));

        // Rollback with 3 ALU + 2 LSB queued; last winner (ALU) must survive the flush.
        rbq.push_back(mk(1,0, 1,1,'h301,0,0, 1,2,'h401, 0,0,6,'h106,0,0, 1,1));
        rbq.push_back(mk(1,0, 1,3,'h302,0,0, 1,4,'h402, 1,1,2,'h401,0,0, 1,1));
        rbq.push_back(mk(1,0, 1,5,'h303,0,0, 1,6,'h403, 1,0,1,'h301,0,0, 1,1));
        rbq.push_back(mk(1,0, 1,7,'h304,0,0, 1,8,'h404, 1,1,4,'h402,0,0, 1,1));
        rbq.push_back(mk(1,0, 1,9,'h305,0,0, 0,0,0, 1,0,3,'h302,0,0, 1,1));
        rbq.push_back(mk(1,1, 1,10,'h306,0,0, 1,11,'h405, 0,0,3,'h302,0,0, 1,1));
        rbq.push_back(mk(1,0, 1,12,'h307,0,0, 1,13,'h406, 0,0,3,'h302,0,0, 1,1));
        rbq.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,1,13,'h406,0,0, 1,1));
        rbq.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,0,12,'h307,0,0, 1,1));
        rbq.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 0,0,12,'h307,0,0, 1,1));

        // rdy low for 3 cycles: bus (including valid) and queues frozen, offered pushes ignored.
        rdq.push_back(mk(1,0, 1,11,'h501,0,0, 1,12,'h601, 0,0,12,'h307,0,0, 1,1));
        rdq.push_back(mk(1,0, 1,13,'h502,0,0, 0,0,0, 1,1,12,'h601,0,0, 1,1));
        for (int k = 0; k < 3; k++) begin
            rdq.push_back(mk(0,0, 1,14,'h503,0,0, 1,15,'h602, 1,1,12,'h601,0,0, 1,1));
        end
        rdq.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,0,11,'h501,0,0, 1,1));
        rdq.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,0,13,'h502,0,0, 1,1));
        rdq.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 0,0,13,'h502,0,0, 1,1));

        // After a mid-run reset: queues empty, ALU wins the first collision again.
        rsq.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1,1));
        rsq.push_back(mk(1,0, 1,1,'h11,0,0, 1,2,'h22, 0,0,0,0,0,0, 1,1));
        rsq.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,0,1,'h11,0,0, 1,1));
        rsq.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 1,1,2,'h22,0,0, 1,1));
        rsq.push_back(mk(1,0, 0,0,0,0,0, 0,0,0, 0,1,2,'h22,0,0, 1,1));

        set_idle();
        rst_n = 1'b0;
        #12;
        check_outs(zero_v, "reset");
        rst_n = 1'b1;
        #1;
        check_outs(zero_v, "post_reset");

        run_seq(tbl, "tbl");
        run_seq(rbq, "rollback");
        run_seq(rdq, "rdy_low");

        // Queue entries, then pull reset asynchronously between edges.
        run_vec(mk(1,0, 1,14,'h701,0,0, 1,15,'h801, 0,0,13,'h502,0,0, 1,1), "pre_async");
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_outs(zero_v, "async_reset");
        #2;
        rst_n = 1'b1;
        run_seq(rsq, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
